decryption_frame_demux: RTL
===========================

Name: decryption_frame_demux

Overview:
- Upstream stage of the decryption datapath. Accepts the encrypted byte stream and buffers it in a small FIFO.
- Routes each frame to one of three decryptor channels: ch0 caesar, ch1 scytale, ch2 zigzag.
- A frame is a run of data bytes terminated by START_DECRYPTION_TOKEN.
- The block never feeds a decryptor that is busy and never switches channel mid-frame.

Parameters:
- D_WIDTH, 8, data byte width.
- FIFO_DEPTH, 4, entries in the input FIFO (power of 2, ≥2).
- MAX_NOF_CHARS, 50, max data bytes per frame (used only with the optional feature).
- START_DECRYPTION_TOKEN, 8'hFA, frame terminator.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst_n  in  1  asynchronous reset, active-low.
- data_i  in  D_WIDTH  incoming encrypted byte.
- valid_i  in  1  data_i valid.
- sel_i  in  2  target channel; sampled only on the first byte of a frame.
- ready_o  out  1  1 = FIFO can accept this cycle.
- busy0_i, busy1_i, busy2_i  in  1 each  busy from the caesar, scytale and zigzag decryptors.
- data0_o, data1_o, data2_o  out  D_WIDTH each  per-channel byte, registered.
- valid0_o, valid1_o, valid2_o  out  1 each  per-channel valid, one-cycle pulses.
- err_o  out  1  frame length overflow, sticky per frame.

Behaviour:
- Reset (async, rst_n=0): FIFO emptied; in_frame=0; FSM=IDLE.
  - All dataX_o=0, validX_o=0, err_o=0, ready_o=0 while rst_n=0.
  - ready_o rises on the first clk edge after release.
- Input side:
  - Byte accepted when valid_i && ready_o; ready_o = !full, using registered full with no same-cycle pop bypass.
  - Each FIFO entry stores {sel, data}.
  - sel is captured from sel_i when in_frame=0 and reused for every later byte of the frame.
  - in_frame is set on the first accepted byte and cleared when the token is accepted.
  - A frame consisting only of the token is legal.
  - A byte offered while full is not accepted; the source must hold it.
- FSM (output side): states IDLE, FWD, WAIT_ACK, WAIT_DONE.
- IDLE:
  - If FIFO non-empty, latch cur_sel from the head entry and go to FWD.
  - No pop happens in the same cycle as the latch.
- FWD:
  - Pop when FIFO non-empty && busy[cur_sel]==0.
  - Popped byte appears on data[cur_sel]_o with valid[cur_sel]_o=1 on the next edge (latency 1 from pop). Other channels keep valid=0.
  - Max 1 byte/cycle.
  - If the popped byte is the token, go to WAIT_ACK.
- WAIT_ACK: wait for busy[cur_sel]==1, then go to WAIT_DONE.
- WAIT_DONE: wait for busy[cur_sel]==0, then go to IDLE.
- No pops occur in WAIT_ACK or WAIT_DONE. Input keeps filling the FIFO with the next frame.
- cur_sel==3 (invalid channel): bytes are popped and discarded with no valid pulse. On the token, go straight to IDLE.
- busy of non-selected channels is ignored.
- Min end-to-end latency: accept at t, IDLE latch at t+1, pop at t+2, validX_o at t+3.
- A simultaneous push and pop when not full both occur; FIFO count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit.
- The token is forwarded to the decryptor like a data byte.

Optional Feature:
- Macro: DEMUX_FRAME_LEN_CHECK_EN.
- With the macro:
  - A per-frame input-side counter counts accepted non-token bytes.
  - Bytes beyond MAX_NOF_CHARS are accepted but not written to the FIFO.
  - err_o goes high on the edge where the first excess byte is accepted.
  - err_o stays high until the frame's token is accepted, then clears on the next edge.
  - The token is always written.
- Without the macro: no counter; err_o is tied 0; every byte is written.

Test Plan:
- Basic route: sel_i=1, send 8'h41,8'h42,8'h43,8'hFA back-to-back with busy1_i=0.
  - Required: valid1_o pulses 4 consecutive cycles with data1_o=41,42,43,FA; valid0_o and valid2_o stay 0.
- Mid-frame select change: sel_i=0 on first byte, then sel_i=2 for the rest of a 3-byte frame.
  - Required: all bytes plus token appear on ch0 only.
- Backpressure: hold busy2_i=1 while sending 6 bytes to ch2.
  - Required: ready_o=0 after 4 accepted, no valid2_o; release busy2_i and all 6 are delivered in order.
- Frame handover: frame A (ch1) token forwarded; bench raises busy1_i 1 cycle later and holds it 10 cycles; frame B (ch0) queued meanwhile.
  - Required: no valid0_o until busy1_i falls, then B delivered.
- Reset mid-frame: assert rst_n=0 after 2 bytes queued.
  - Required: outputs 0 immediately, FIFO empty; the next frame after release routes with a fresh sel_i.
- With DEMUX_FRAME_LEN_CHECK_EN and MAX_NOF_CHARS=3, send 5 bytes then 8'hFA.
  - Required: only 3 bytes plus FA forwarded; err_o high from the 4th byte until after the token.

Source files
------------

// File: rtl/decryption_frame_demux_if.sv
// decryption_frame_demux_if: encrypted byte stream in, three decryptor channels out.
interface decryption_frame_demux_if #(
    parameter int D_WIDTH = 8
);
    logic [D_WIDTH-1:0] data_i;
    logic               valid_i;
    logic [1:0]         sel_i;
    logic               ready_o;
    logic               busy0_i, busy1_i, busy2_i;
    logic [D_WIDTH-1:0] data0_o, data1_o, data2_o;
    logic               valid0_o, valid1_o, valid2_o;
    logic               err_o;

    modport master (
        output data_i, valid_i, sel_i, busy0_i, busy1_i, busy2_i,
        input  ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o, err_o
    );

    modport slave (
        input  data_i, valid_i, sel_i, busy0_i, busy1_i, busy2_i,
        output ready_o, data0_o, data1_o, data2_o, valid0_o, valid1_o, valid2_o, err_o
    );
endinterface

// File: rtl/decryption_frame_demux.sv
// decryption_frame_demux: buffers encrypted bytes and routes whole frames to caesar/scytale/zigzag.
// Define DEMUX_FRAME_LEN_CHECK_EN to drop bytes past MAX_NOF_CHARS per frame and raise err_o.
module decryption_frame_demux #(
    parameter int                 D_WIDTH                = 8,
    parameter int                 FIFO_DEPTH             = 4,
    parameter int                 MAX_NOF_CHARS          = 50,
    parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
    input logic                  clk,
    input logic                  rst_n,
    decryption_frame_demux_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || MAX_NOF_CHARS < 1) begin : g_param_check
        $error("decryption_frame_demux: bad FIFO_DEPTH or MAX_NOF_CHARS");
    end

    typedef enum logic [1:0] {IDLE, FWD, WAIT_ACK, WAIT_DONE} state_t;

    state_t             state, state_nxt;
    logic [D_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic               ready_q, in_frame, acc, is_tok, wr_en, push, pop, empty, sel_busy;
    logic [1:0]         frame_sel, sel_in, cur_sel, head_sel;
    logic [D_WIDTH-1:0] head_data;
    logic [D_WIDTH-1:0] dq [3];
    logic [2:0]         vq;
    logic [3:0]         busy_v;

    assign acc       = bus.valid_i && ready_q;
    assign is_tok    = bus.data_i == START_DECRYPTION_TOKEN;
    assign sel_in    = in_frame ? frame_sel : bus.sel_i;
    assign push      = acc && wr_en;
    assign empty     = wr_ptr == rd_ptr;
    assign {head_sel, head_data} = mem[rd_ptr[AW-1:0]];
    // channel 3 has no decryptor, so it never stalls and its bytes are just drained
    assign busy_v    = {1'b0, bus.busy2_i, bus.busy1_i, bus.busy0_i};
    assign sel_busy  = busy_v[cur_sel];
    assign pop       = state == FWD && !empty && !sel_busy;
    assign wr_nxt    = wr_ptr + (AW+1)'(push);
    assign rd_nxt    = rd_ptr + (AW+1)'(pop);
    assign bus.ready_o = ready_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ready_q   <= 1'b0;
            in_frame  <= 1'b0;
            frame_sel <= '0;
        end else begin
            wr_ptr  <= wr_nxt;
            rd_ptr  <= rd_nxt;
            ready_q <= (wr_nxt ^ rd_nxt) != {1'b1, {AW{1'b0}}};
            if (acc) begin
                in_frame <= !is_tok;
                if (!in_frame) frame_sel <= bus.sel_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {sel_in, bus.data_i};
    end

`ifdef DEMUX_FRAME_LEN_CHECK_EN
    localparam int LW = $clog2(MAX_NOF_CHARS + 1);
    logic [LW-1:0] len_cnt;
    logic          err_q;

    assign wr_en     = is_tok || len_cnt < LW'(MAX_NOF_CHARS);
    assign bus.err_o = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_cnt <= '0;
            err_q   <= 1'b0;
        end else if (acc) begin
            if (is_tok) begin
                len_cnt <= '0;
                err_q   <= 1'b0;
            end else if (wr_en) begin
                len_cnt <= len_cnt + 1'b1;
            end else begin
                err_q <= 1'b1;
            end
        end
    end
`else
    assign wr_en     = 1'b1;
    assign bus.err_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cur_sel <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && !empty) cur_sel <= head_sel;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = empty ? IDLE : FWD;
            FWD:       if (pop && head_data == START_DECRYPTION_TOKEN) state_nxt = cur_sel == 2'd3 ? IDLE : WAIT_ACK;
            WAIT_ACK:  state_nxt = sel_busy ? WAIT_DONE : WAIT_ACK;
            WAIT_DONE: state_nxt = sel_busy ? WAIT_DONE : IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vq <= '0;
            for (int k = 0; k < 3; k++) dq[k] <= '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                vq[k] <= pop && cur_sel == 2'(k);
                if (pop && cur_sel == 2'(k)) dq[k] <= head_data;
            end
        end
    end

    assign bus.data0_o  = dq[0];
    assign bus.data1_o  = dq[1];
    assign bus.data2_o  = dq[2];
    assign bus.valid0_o = vq[0];
    assign bus.valid1_o = vq[1];
    assign bus.valid2_o = vq[2];
endmodule
